// File: rtl/delay_probe_if.sv
// Probe-side bus of delay_probe: start/result handshake plus the data words
// exchanged with the delay line. err_cnt exists only with DELAY_PROBE_ERRCNT_EN.
interface delay_probe_if #(
  parameter int N  = 5,
  parameter int CW = 5
);
  logic          start;
  logic [N-1:0]  idata;
  logic [N-1:0]  odata;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [CW-1:0] delay;
`ifdef DELAY_PROBE_ERRCNT_EN
  logic [7:0]    err_cnt;

  modport slave  (input  start, idata,
                  output odata, busy, done, timeout, delay, err_cnt);
  modport master (output start, idata,
                  input  odata, busy, done, timeout, delay, err_cnt);
`else
  modport slave  (input  start, idata,
                  output odata, busy, done, timeout, delay);
  modport master (output start, idata,
                  input  odata, busy, done, timeout, delay);
`endif
endinterface

// File: rtl/delay_probe.sv
// Latency probe for a ce-gated delay line: flush, send one marker, count ce-cycles
// until it returns. Optional timeout counter: define DELAY_PROBE_ERRCNT_EN.
module delay_probe #(
  parameter int           N         = 5,
  parameter int           MAX_DELAY = 16,
  parameter logic [N-1:0] PATTERN   = 5'h15,
  parameter logic [N-1:0] IDLE_WORD = 5'h00
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  delay_probe_if.slave  bus
);
  localparam int            CW      = $clog2(MAX_DELAY + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_DELAY);

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_WAIT} state_t;

  state_t        r_state, w_state;
  logic [CW-1:0] r_cnt,   w_cnt;
  logic [N-1:0]  r_odata, w_odata;
  logic          r_busy,  w_busy;
  logic          r_done,  w_done;
  logic          r_to,    w_to;
  logic [CW-1:0] r_delay, w_delay;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_odata <= IDLE_WORD;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_to    <= 1'b0;
      r_delay <= '0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_odata <= w_odata;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_to    <= w_to;
      r_delay <= w_delay;
    end
  end

  // Pulses default low every clk, so they stay one clk wide even when ce drops.
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_odata = r_odata;
    w_busy  = r_busy;
    w_done  = 1'b0;
    w_to    = 1'b0;
    w_delay = r_delay;
    if (ce) begin
      case (r_state)
        S_IDLE: begin
          w_odata = IDLE_WORD;
          if (bus.start) begin
            w_state = S_FLUSH;
            w_cnt   = '0;
            w_busy  = 1'b1;
          end
        end
        S_FLUSH: begin
          if (r_cnt == CNT_MAX) begin
            w_odata = PATTERN;
            w_cnt   = '0;
            w_state = S_WAIT;
          end else begin
            w_odata = IDLE_WORD;
            w_cnt   = r_cnt + CW'(1);
          end
        end
        S_WAIT: begin
          w_odata = IDLE_WORD;
          // Marker match takes priority over the timeout on the last count.
          if (bus.idata == PATTERN) begin
            w_delay = r_cnt;
            w_done  = 1'b1;
            w_busy  = 1'b0;
            w_state = S_IDLE;
          end else if (r_cnt == CNT_MAX) begin
            w_to    = 1'b1;
            w_busy  = 1'b0;
            w_state = S_IDLE;
          end else begin
            w_cnt   = r_cnt + CW'(1);
          end
        end
        default: begin
          w_state = S_IDLE;
          w_odata = IDLE_WORD;
          w_busy  = 1'b0;
        end
      endcase
    end
  end

`ifdef DELAY_PROBE_ERRCNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_err_cnt <= 8'h00;
    else if (w_to && r_err_cnt != 8'hFF)
      r_err_cnt <= r_err_cnt + 8'h01;
  end

  assign bus.err_cnt = r_err_cnt;
`endif

  assign bus.odata   = r_odata;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.timeout = r_to;
  assign bus.delay   = r_delay;

endmodule

// File: tb/tb_delay_probe.sv
// Bench for delay_probe: drives a ce-gated register delay line model and checks the
// probe every cycle against a ce-edge timeline model, plus directed literal checks.
module tb_delay_probe;
  localparam int           N    = 5;
  localparam int           MAXD = 16;
  localparam int           CW   = $clog2(MAXD + 1);
  localparam logic [N-1:0] PAT  = 5'h15;
  localparam logic [N-1:0] IDLE = 5'h00;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic ce    = 1'b0;
  int   ce_mode = 0;
  int   D       = 4;
  int   lmode   = 0;
  logic [N-1:0] noise;
  logic [N-1:0] line [0:23];
  logic [N-1:0] lineout;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  delay_probe_if #(.N(N), .CW(CW)) bus ();

  delay_probe #(.N(N), .MAX_DELAY(MAXD), .PATTERN(PAT), .IDLE_WORD(IDLE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (ce),
    .bus   (bus)
  );

  // Delay line under test: D ce-gated registers (D=0 is a wire).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 24; i++) line[i] <= IDLE;
    end else if (ce) begin
      line[0] <= bus.odata;
      for (int i = 1; i < 24; i++) line[i] <= line[i-1];
    end
  end

  always @(negedge clk) begin
    noise = N'($urandom_range(1, 31));
    if (noise == PAT) noise = 5'h0A;
  end

  always_comb begin
    lineout = (D == 0) ? bus.odata : line[D-1];
    case (lmode)
      1:       bus.idata = IDLE;
      2:       bus.idata = (lineout == PAT) ? PAT : noise;
      default: bus.idata = lineout;
    endcase
  end

  always @(negedge clk) begin
    case (ce_mode)
      0:       ce = 1'b1;
      1:       ce = ~ce;
      default: ce = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Reference: count ce-edges since acceptance. Marker leaves on edge MAXD+1, and
  // edge MAXD+2+w inspects idata for a delay of w.
  bit           m_act;
  int           m_rel;
  logic [N-1:0] m_odata;
  bit           m_busy, m_done, m_to;
  int           m_delay, m_err;
  int           n_done = 0, n_to = 0;

  always @(posedge clk or negedge rst_n) begin
    int w;
    if (!rst_n) begin
      m_act = 0; m_rel = 0; m_odata = IDLE; m_busy = 0;
      m_done = 0; m_to = 0; m_delay = 0; m_err = 0;
    end else begin
      m_done = 0;
      m_to   = 0;
      if (ce) begin
        if (!m_act) begin
          m_odata = IDLE;
          if (bus.start) begin m_act = 1; m_rel = 0; m_busy = 1; end
        end else begin
          m_rel++;
          m_odata = (m_rel == MAXD + 1) ? PAT : IDLE;
          if (m_rel > MAXD + 1) begin
            w = m_rel - (MAXD + 2);
            if (bus.idata == PAT) begin
              m_done = 1; m_delay = w; m_busy = 0; m_act = 0; n_done++;
            end else if (w == MAXD) begin
              m_to = 1; m_busy = 0; m_act = 0; n_to++;
              if (m_err < 255) m_err++;
            end
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("odata",   int'(bus.odata),   int'(m_odata));
      chk("busy",    int'(bus.busy),    int'(m_busy));
      chk("done",    int'(bus.done),    int'(m_done));
      chk("timeout", int'(bus.timeout), int'(m_to));
      chk("delay",   int'(bus.delay),   m_delay);
`ifdef DELAY_PROBE_ERRCNT_EN
      chk("err_cnt", int'(bus.err_cnt), m_err);
`endif
    end
  end

  // One measurement: hold start until accepted, then count samples while busy plus
  // the final done/timeout sample.
  task automatic run(input int bound, output int len);
    int k;
    len = 0;
    k = 0;
    bus.start = 1'b1;
    do begin @(negedge clk); k++; end while (!bus.busy && k < bound);
    bus.start = 1'b0;
    while (bus.busy && k < bound) begin len++; @(negedge clk); k++; end
    if (bus.done || bus.timeout) len++;
    if (k >= bound) begin
      n_cmp++; n_bad++;
      $display("FAIL run_bound: got %0d cycles expected under %0d", k, bound);
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_odata"},   int'(bus.odata),   int'(IDLE));
    chk({nm, "_busy"},    int'(bus.busy),    0);
    chk({nm, "_done"},    int'(bus.done),    0);
    chk({nm, "_timeout"}, int'(bus.timeout), 0);
    chk({nm, "_delay"},   int'(bus.delay),   0);
`ifdef DELAY_PROBE_ERRCNT_EN
    chk({nm, "_err"},     int'(bus.err_cnt), 0);
`endif
  endtask

  initial begin
    int len, d0, t0, k;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // 1: four-register line
    D = 4; lmode = 0; ce_mode = 0;
    d0 = n_done;
    run(200, len);
    chk("t1_len",   len, 23);
    chk("t1_delay", int'(bus.delay), 4);
    chk("t1_ndone", n_done - d0, 1);

    // 2: one register, then a dead line times out
    D = 1;
    run(200, len);
    chk("t2_delay1", int'(bus.delay), 1);
    lmode = 1;
    d0 = n_done; t0 = n_to;
    run(200, len);
    chk("t2_len",   len, 35);
    chk("t2_nto",   n_to - t0, 1);
    chk("t2_ndone", n_done - d0, 0);
    chk("t2_delay", int'(bus.delay), 1);

    // combinational line and the longest measurable line
    lmode = 0; D = 0;
    run(200, len);
    chk("t2_d0", int'(bus.delay), 0);
    D = MAXD;
    run(200, len);
    chk("t2_dmax", int'(bus.delay), MAXD);

    // 3: ce toggling
    D = 4; ce_mode = 1;
    run(400, len);
    chk("t3_delay", int'(bus.delay), 4);
    ce_mode = 0;
    D = 9;
    @(negedge clk);

    // 4: start repeated in FLUSH, WAIT and on the finishing edge
    D = 4;
    d0 = n_done;
    bus.start = 1'b1;
    @(negedge clk);
    for (k = 0; k <= 30; k++) begin
      bus.start = (k == 5 || k == 6 || k == 19 || k == 20 || k == 21);
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk("t4_ndone", n_done - d0, 1);
    chk("t4_busy",  int'(bus.busy), 0);
    chk("t4_delay", int'(bus.delay), 4);

    // 5: reset in the middle of WAIT
    D = 7;
    run(200, len);
    D = 4;
    d0 = n_done; t0 = n_to;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("t5");
    repeat (3) @(negedge clk);
    chk("t5_ndone", n_done - d0, 0);
    chk("t5_nto",   n_to - t0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    run(200, len);
    chk("t5_delay", int'(bus.delay), 4);

`ifdef DELAY_PROBE_ERRCNT_EN
    // 6a: three timeouts since reset
    lmode = 1;
    repeat (3) run(200, len);
    chk("t6_err3", int'(bus.err_cnt), 3);
    lmode = 0;
`endif

    // random ce, start, line length and noise
    ce_mode = 2;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c % 200 == 0) begin
        D = $urandom_range(0, 18);
        k = $urandom_range(0, 4);
        lmode = (k == 4) ? 1 : (k == 3) ? 2 : 0;
      end
      bus.start = ($urandom_range(0, 7) == 0);
    end
    bus.start = 1'b0;
    k = 0;
    while (bus.busy && k < 200) begin @(negedge clk); k++; end
    chk("rnd_idle", int'(bus.busy), 0);
    ce_mode = 0;

`ifdef DELAY_PROBE_ERRCNT_EN
    // 6b: saturation
    lmode = 1;
    repeat (300) run(200, len);
    chk("t6_sat", int'(bus.err_cnt), 255);
    lmode = 0;
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
